// File: rtl/arbiter_access_mc.sv
// rtl/arbiter_access_mc.sv - multi-channel round-robin front end for the buffer read/write arbiters
//
// Purpose:
//   Picks one of N_CH client commands round-robin, forwards it as a read or
//   write request to the matching buffer arbiter, holds the request until it
//   is granted or times out, and reports completion with channel, direction
//   and error status.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ch_valid_i / ch_ready_o  per-channel command handshake (ready one-hot or zero)
//   ch_rd_or_wr_i            per-channel direction, 1 = read
//   ch_addr_i                per-channel address, ch i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   arbiter_read_*           read arbiter request/grant and source address
//   arbiter_write_*          write arbiter request/grant and destination address
//   done_*_o                 one-cycle completion report
//   busy_o                   high whenever a transaction is in flight
module arbiter_access_mc #(
  parameter int N_CH           = 4,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CH_W          = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            ch_valid_i,
  output logic [N_CH-1:0]            ch_ready_o,
  input  logic [N_CH-1:0]            ch_rd_or_wr_i,
  input  logic [N_CH*ADDR_WIDTH-1:0] ch_addr_i,
  input  logic                       arbiter_read_gnt,
  output logic                       arbiter_read_req,
  output logic [ADDR_WIDTH-1:0]      arbiter_src_addr,
  input  logic                       arbiter_write_gnt,
  output logic                       arbiter_write_req,
  output logic [ADDR_WIDTH-1:0]      arbiter_dst_addr,
  output logic                       done_valid_o,
  output logic [CH_W-1:0]            done_ch_o,
  output logic                       done_is_read_o,
  output logic                       done_err_o,
  output logic                       busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_REQ  = 2'd1,
    WRITE_REQ = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                state_q, state_n;
  logic [CH_W-1:0]       rr_ptr_q;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic                  err_q, err_n;
  logic [CH_W-1:0]       ch_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  dir_q;

  logic                  win_found;
  logic [CH_W-1:0]       win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_dir;
  logic                  accept;
  logic                  gnt_active;
  logic                  timeout_hit;

  // Circular scan from rr_ptr. Walking the offsets downwards lets the
  // smallest offset with a valid request overwrite any larger one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (ch_valid_i[idx]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(idx);
      end
    end
  end

  assign win_addr = ch_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_dir  = ch_rd_or_wr_i[win_idx];
  assign accept   = (state_q == IDLE) && win_found;

  // Ready is the only combinational output; it is masked during reset so the
  // block shows all-zero outputs while rst is held.
  assign ch_ready_o = (accept && !rst) ? (N_CH'(1) << win_idx) : '0;

  // Only the grant matching the current request direction is observed.
  assign gnt_active  = (state_q == READ_REQ)  ? arbiter_read_gnt  :
                       (state_q == WRITE_REQ) ? arbiter_write_gnt : 1'b0;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_n = win_dir ? READ_REQ : WRITE_REQ;
          cnt_n   = '0;
          err_n   = 1'b0;
        end
      end
      READ_REQ, WRITE_REQ: begin
        if (gnt_active) begin
          state_n = DONE;
          err_n   = 1'b0;
        end else if (timeout_hit) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ch_q     <= '0;
      addr_q   <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      if (accept) begin
        ch_q     <= win_idx;
        addr_q   <= win_addr;
        dir_q    <= win_dir;
        rr_ptr_q <= (win_idx == CH_W'(N_CH - 1)) ? '0 : win_idx + CH_W'(1);
      end
    end
  end

  assign arbiter_read_req  = (state_q == READ_REQ);
  assign arbiter_write_req = (state_q == WRITE_REQ);
  assign arbiter_src_addr  = arbiter_read_req  ? addr_q : '0;
  assign arbiter_dst_addr  = arbiter_write_req ? addr_q : '0;

  assign done_valid_o   = (state_q == DONE);
  assign done_ch_o      = done_valid_o ? ch_q  : '0;
  assign done_is_read_o = done_valid_o ? dir_q : 1'b0;
  assign done_err_o     = done_valid_o ? err_q : 1'b0;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_arbiter_access_mc.sv
// tb/tb_arbiter_access_mc.sv - self-checking bench for arbiter_access_mc
module tb_arbiter_access_mc;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int TO = 64;
  localparam int CW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    ch_valid = '0;
  logic [N-1:0]    ch_ready;
  logic [N-1:0]    ch_rd = '0;
  logic [N*AW-1:0] ch_addr = '0;
  logic            rd_gnt = 1'b0;
  logic            rd_req;
  logic [AW-1:0]   src_addr;
  logic            wr_gnt = 1'b0;
  logic            wr_req;
  logic [AW-1:0]   dst_addr;
  logic            done_valid;
  logic [CW-1:0]   done_ch;
  logic            done_rd;
  logic            done_err;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;
  int ptr         = 0;

  always #5 clk = ~clk;

  arbiter_access_mc #(.N_CH(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
    .ch_rd_or_wr_i(ch_rd), .ch_addr_i(ch_addr),
    .arbiter_read_gnt(rd_gnt), .arbiter_read_req(rd_req), .arbiter_src_addr(src_addr),
    .arbiter_write_gnt(wr_gnt), .arbiter_write_req(wr_req), .arbiter_dst_addr(dst_addr),
    .done_valid_o(done_valid), .done_ch_o(done_ch), .done_is_read_o(done_rd),
    .done_err_o(done_err), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string ph, input logic rr, input logic [AW-1:0] sa,
                            input logic wr, input logic [AW-1:0] da, input logic dv,
                            input logic [CW-1:0] dc, input logic dr, input logic de,
                            input logic by, input logic [N-1:0] rdy);
    chk({ph, ".rd_req"},   32'(rd_req),     32'(rr));
    chk({ph, ".src_addr"}, 32'(src_addr),   32'(sa));
    chk({ph, ".wr_req"},   32'(wr_req),     32'(wr));
    chk({ph, ".dst_addr"}, 32'(dst_addr),   32'(da));
    chk({ph, ".done_v"},   32'(done_valid), 32'(dv));
    chk({ph, ".done_ch"},  32'(done_ch),    32'(dc));
    chk({ph, ".done_rd"},  32'(done_rd),    32'(dr));
    chk({ph, ".done_err"}, 32'(done_err),   32'(de));
    chk({ph, ".busy"},     32'(busy),       32'(by));
    chk({ph, ".ready"},    32'(ch_ready),   32'(rdy));
  endtask

  // Reference winner: first valid channel walking circularly from ptr.
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'($urandom);
    return r;
  endfunction

  // One full transaction starting at a negedge with the DUT idle.
  // gd: request cycle index on which the matching grant is given.
  // noise: 0 none, 1 random, 2 constant opposite-direction grant.
  task automatic txn(input logic [N-1:0] mask, input logic [N-1:0] dirs,
                     input logic [N*AW-1:0] addrs, input int gd, input int noise,
                     input bit hold);
    int            w;
    int            c;
    bit            last;
    logic          is_rd;
    logic          err;
    logic [AW-1:0] a;
    ch_valid = mask;
    ch_rd    = dirs;
    ch_addr  = addrs;
    rd_gnt   = 1'b0;
    wr_gnt   = 1'b0;
    #1;
    w     = pick(mask);
    is_rd = dirs[w];
    a     = addrs[w*AW +: AW];
    err   = (TO > 0) && (gd > TO - 1);
    expect_out("idle", 0, '0, 0, '0, 0, '0, 0, 0, 0, N'(1) << w);
    ptr = (w + 1) % N;
    @(negedge clk);
    if (!hold) ch_valid = '0;
    ch_rd   = N'($urandom);
    ch_addr = rand_addrs();
    c = 0;
    forever begin
      logic nz;
      nz = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom) : 1'b0;
      rd_gnt = is_rd ? (c == gd) : nz;
      wr_gnt = is_rd ? nz : (c == gd);
      #1;
      expect_out("req", is_rd, is_rd ? a : '0, !is_rd, is_rd ? '0 : a,
                 0, '0, 0, 0, 1, '0);
      last = (c == gd) || (TO > 0 && c == TO - 1);
      c++;
      @(negedge clk);
      if (last) break;
    end
    rd_gnt = 1'($urandom);
    wr_gnt = 1'($urandom);
    #1;
    expect_out("done", 0, '0, 0, '0, 1, CW'(w), is_rd, err, 1, '0);
    @(negedge clk);
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
  endtask

  initial begin
    logic [N*AW-1:0] ad;

    // Reset held two cycles with every channel requesting.
    rst      = 1'b1;
    ch_valid = '1;
    ch_rd    = '1;
    repeat (2) begin
      @(negedge clk);
      #1;
      expect_out("reset", 0, '0, 0, '0, 0, '0, 0, 0, 0, '0);
    end
    rst = 1'b0;
    #1;
    chk("first_ready", 32'(ch_ready), 32'h1);
    ptr = 0;

    // Round-robin with all channels held valid and immediate grant.
    for (int t = 0; t < 5; t++) txn('1, N'($urandom), rand_addrs(), 0, 0, 1'b1);

    // Single read on ch2, addr 0x155, granted on the third request cycle.
    ad = rand_addrs();
    ad[2*AW +: AW] = 10'h155;
    txn(4'b0100, 4'b0100, ad, 2, 0, 1'b0);

    // Timeout: ch1 write to 0x3FF never granted.
    ad = rand_addrs();
    ad[1*AW +: AW] = 10'h3FF;
    txn(4'b0010, 4'b0000, ad, TO + 10, 1, 1'b0);

    // After the timeout the pointer sits at ch2.
    txn('1, N'($urandom), rand_addrs(), 1, 1, 1'b0);

    // Wrong-direction grant held high all along, read completes later.
    txn(4'b0001, 4'b0001, rand_addrs(), 5, 2, 1'b0);

    // Grant coincides with the timeout cycle.
    txn(4'b0001, 4'b0001, rand_addrs(), TO - 1, 1, 1'b0);
    txn(4'b1000, 4'b0000, rand_addrs(), TO - 1, 1, 1'b0);

    // Mid-operation reset during a ch2 read.
    ch_valid = 4'b0100;
    ch_rd    = 4'b0100;
    ch_addr  = rand_addrs();
    @(negedge clk);
    ch_valid = '0;
    #1;
    chk("mid.rd_req_before", 32'(rd_req), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_out("mid.after", 0, '0, 0, '0, 0, '0, 0, 0, 0, '0);
    ch_valid = '1;
    #1;
    chk("mid.ready_ch0", 32'(ch_ready), 32'h1);
    ch_valid = '0;
    @(negedge clk);
    #1;
    expect_out("mid.nodone", 0, '0, 0, '0, 0, '0, 0, 0, 0, '0);
    ptr = 0;

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int gd;
      case ($urandom_range(0, 9))
        0:       gd = TO - 1;
        1:       gd = TO + 3;
        default: gd = $urandom_range(0, 6);
      endcase
      txn(N'($urandom_range(1, (1 << N) - 1)), N'($urandom), rand_addrs(),
          gd, 1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
